// File: rtl/axi_dac_jesd204_dma_fifo.sv
// Rate-matching FIFO feeding one DAC JESD204 channel: primes to START_LEVEL beats,
// then streams one beat per dac_clk, substituting zeros and counting underflows.
module axi_dac_jesd204_dma_fifo #(
   parameter int DATA_PATH_WIDTH = 4,
   parameter int DEPTH_LOG2      = 4,
   parameter int START_LEVEL     = 8
) (
   input  logic                            dac_clk,
   input  logic                            dac_rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_PATH_WIDTH*16-1:0]   s_data,
   input  logic                            dac_enable,
   input  logic                            dac_data_sync,
   output logic [DATA_PATH_WIDTH*16-1:0]   dma_data,
   output logic                            dac_dunf,
   input  logic                            dunf_clr,
   output logic [15:0]                     dunf_count,
   output logic [DEPTH_LOG2:0]             fill_level
);

   localparam int DW    = DATA_PATH_WIDTH * 16;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;

   localparam lvl_t FULL_LVL  = lvl_t'(DEPTH);
   localparam lvl_t START_LVL = lvl_t'(START_LEVEL);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t          state_q;
   ptr_t            wr_ptr_q, rd_ptr_q;
   lvl_t            fill_q, fill_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   dma_data_q;
   logic            dunf_q;
   logic [15:0]     dunf_cnt_q;
   logic            push, pop, underflow;

   // Ready is held low while reset is asserted so a beat offered during reset is never taken.
   assign s_ready   = !dac_rst && (fill_q < FULL_LVL);
   assign push      = s_valid && s_ready && !dac_data_sync;
   assign pop       = (state_q == RUN) && dac_enable && !dac_data_sync && (fill_q != '0);
   assign underflow = (state_q == RUN) && dac_enable && !dac_data_sync && (fill_q == '0);
   assign fill_d    = fill_q + lvl_t'(push) - lvl_t'(pop);

   // NOTE: the storage array has no reset; only pointers and occupancy define valid contents.
   always_ff @(posedge dac_clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         dma_data_q <= '0;
         dunf_q     <= 1'b0;
         dunf_cnt_q <= '0;
      end else begin
         // An underflow in the same cycle as a clear wins, leaving a count of one.
         if (underflow) begin
            dunf_q     <= 1'b1;
            dunf_cnt_q <= dunf_clr ? 16'd1 :
                          (dunf_cnt_q == 16'hFFFF) ? dunf_cnt_q : dunf_cnt_q + 16'd1;
         end else if (dunf_clr) begin
            dunf_q     <= 1'b0;
            dunf_cnt_q <= '0;
         end

         if (dac_data_sync) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            dma_data_q <= '0;
         end else begin
            fill_q     <= fill_d;
            dma_data_q <= pop ? mem_q[rd_ptr_q] : '0;
            if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            case (state_q)
               IDLE:    if (dac_enable) state_q <= FILL;
               FILL:    if (!dac_enable) state_q <= IDLE;
                        else if (fill_q >= START_LVL) state_q <= RUN;
               RUN:     if (!dac_enable) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign dma_data   = dma_data_q;
   assign dac_dunf   = dunf_q;
   assign dunf_count = dunf_cnt_q;
   assign fill_level = fill_q;

endmodule

// File: tb/tb_axi_dac_jesd204_dma_fifo.sv
// Self-checking bench for axi_dac_jesd204_dma_fifo: a directed vector table plus
// directed and random sequences scored against a queue-based reference model.
module tb_axi_dac_jesd204_dma_fifo;

   localparam int DPW   = 4;
   localparam int DL2   = 4;
   localparam int SL    = 8;
   localparam int DW    = DPW * 16;
   localparam int DEPTH = 2 ** DL2;

   localparam int M_IDLE   = 0;
   localparam int M_PRIME  = 1;
   localparam int M_STREAM = 2;

   logic            dac_clk = 1'b0;
   logic            dac_rst, s_valid, s_ready, dac_enable, dac_data_sync, dunf_clr, dac_dunf;
   logic [DW-1:0]   s_data, dma_data;
   logic [15:0]     dunf_count;
   logic [DL2:0]    fill_level;

   always #5 dac_clk = ~dac_clk;

   axi_dac_jesd204_dma_fifo #(
      .DATA_PATH_WIDTH (DPW),
      .DEPTH_LOG2      (DL2),
      .START_LEVEL     (SL)
   ) dut (
      .dac_clk       (dac_clk),
      .dac_rst       (dac_rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .dac_enable    (dac_enable),
      .dac_data_sync (dac_data_sync),
      .dma_data      (dma_data),
      .dac_dunf      (dac_dunf),
      .dunf_clr      (dunf_clr),
      .dunf_count    (dunf_count),
      .fill_level    (fill_level)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of beats plus the priming/streaming mode.
   logic [DW-1:0] mq[$];
   int            mode  = M_IDLE;
   logic [DW-1:0] m_dout = '0;
   bit            m_dunf = 1'b0;
   int            m_cnt  = 0;

   task automatic model_step();
      int old = mq.size();
      bit uf  = 1'b0;
      if (dac_rst) begin
         mq.delete(); mode = M_IDLE; m_dout = '0; m_dunf = 1'b0; m_cnt = 0;
      end else if (dac_data_sync) begin
         mq.delete(); mode = M_IDLE; m_dout = '0;
         if (dunf_clr) begin m_dunf = 1'b0; m_cnt = 0; end
      end else begin
         m_dout = '0;
         if (mode == M_IDLE) begin
            if (dac_enable) mode = M_PRIME;
         end else if (mode == M_PRIME) begin
            if (!dac_enable) mode = M_IDLE;
            else if (old >= SL) mode = M_STREAM;
         end else begin
            if (!dac_enable) mode = M_IDLE;
            else if (old > 0) m_dout = mq.pop_front();
            else uf = 1'b1;
         end
         if (dunf_clr) begin m_dunf = 1'b0; m_cnt = 0; end
         if (uf) begin
            m_dunf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
         if (s_valid && old < DEPTH) mq.push_back(s_data);
      end
   endtask

   task automatic compare_model();
      check("dma_data",   64'(dma_data),   64'(m_dout));
      check("fill_level", 64'(fill_level), 64'(mq.size()));
      check("s_ready",    64'(s_ready),    64'(!dac_rst && mq.size() < DEPTH));
      check("dac_dunf",   64'(dac_dunf),   64'(m_dunf));
      check("dunf_count", 64'(dunf_count), 64'(m_cnt));
   endtask

   task automatic drive(input bit rst, input bit valid, input logic [DW-1:0] data,
                        input bit en, input bit sync, input bit clr);
      dac_rst = rst; s_valid = valid; s_data = data;
      dac_enable = en; dac_data_sync = sync; dunf_clr = clr;
   endtask

   // Inputs change only #1 after the rising edge; outputs are sampled there too.
   task automatic cycle(input bit chk);
      @(posedge dac_clk);
      #1;
      model_step();
      if (chk) compare_model();
   endtask

   typedef struct {
      bit            rst, valid, en, sync, clr;
      logic [DW-1:0] data;
      logic [DL2:0]  e_fill;
      logic [DW-1:0] e_data;
      bit            e_dunf;
      logic [15:0]   e_cnt;
      bit            e_ready;
   } vec_t;

   function automatic vec_t mk(input bit rst, input bit valid, input int data, input bit en,
                               input bit sync, input bit clr, input int e_fill, input int e_data,
                               input bit e_dunf, input int e_cnt, input bit e_ready);
      vec_t v;
      v.rst = rst; v.valid = valid; v.data = DW'(data); v.en = en; v.sync = sync; v.clr = clr;
      v.e_fill = (DL2+1)'(e_fill); v.e_data = DW'(e_data); v.e_dunf = e_dunf;
      v.e_cnt = 16'(e_cnt); v.e_ready = e_ready;
      return v;
   endfunction

   vec_t          tbl[20];
   logic [DW-1:0] base;

   initial begin
      // Priming from reset: beats 1..8, stream out in order, one underflow, then a clear.
      tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 1, i, 1, 0, 0, i, 0, 0, 0, 1);
      tbl[9] = mk(0, 0, 0, 1, 0, 0, 8, 0, 0, 0, 1);
      for (int k = 1; k <= 8; k++) tbl[9+k] = mk(0, 0, 0, 1, 0, 0, 8-k, k, 0, 0, 1);
      tbl[18] = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
      tbl[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

      drive(1, 0, '0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].en, tbl[i].sync, tbl[i].clr);
         cycle(0);
         check($sformatf("vec%0d.fill", i),  64'(fill_level), 64'(tbl[i].e_fill));
         check($sformatf("vec%0d.data", i),  64'(dma_data),   64'(tbl[i].e_data));
         check($sformatf("vec%0d.dunf", i),  64'(dac_dunf),   64'(tbl[i].e_dunf));
         check($sformatf("vec%0d.cnt", i),   64'(dunf_count), 64'(tbl[i].e_cnt));
         check($sformatf("vec%0d.ready", i), 64'(s_ready),    64'(tbl[i].e_ready));
      end

      // Fill to full while disabled; further writes must be refused.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, {$urandom, $urandom}, 0, 0, 0);
         cycle(1);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, {$urandom, $urandom}, 0, 0, 0);
         cycle(1);
         check("full.s_ready", 64'(s_ready), 64'(0));
         check("full.fill",    64'(fill_level), 64'(DEPTH));
      end
      // Enable: prime (2 cycles), drain 16, then 5 underflow cycles.
      drive(0, 0, '0, 1, 0, 0);
      for (int i = 0; i < 2 + DEPTH + 5; i++) cycle(1);
      check("unf5.cnt",  64'(dunf_count), 64'(5));
      check("unf5.dunf", 64'(dac_dunf),   64'(1));
      drive(0, 0, '0, 0, 0, 1);
      cycle(1);
      check("clr.cnt",  64'(dunf_count), 64'(0));
      check("clr.dunf", 64'(dac_dunf),   64'(0));

      // Sync mid-stream with 6 beats queued and a beat offered at the same time.
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, DW'(64'h100 + i), 1, 0, 0);
         cycle(1);
      end
      drive(0, 0, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1);
      check("presync.fill", 64'(fill_level), 64'(6));
      drive(0, 1, DW'(64'hDEAD), 1, 1, 0);
      cycle(1);
      check("sync.fill", 64'(fill_level), 64'(0));
      check("sync.data", 64'(dma_data),   64'(0));

      // Re-prime with new beats, then sustained push+pop of 1000 incrementing beats.
      base = 64'h0123_4567_89AB_0000;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, base + DW'(i), 1, 0, 0);
         cycle(1);
      end
      drive(0, 0, '0, 1, 0, 0);
      cycle(1);
      for (int i = 0; i < 1000; i++) begin
         drive(0, 1, base + DW'(8 + i), 1, 0, 0);
         cycle(1);
         if (i == 0) check("resync.first", 64'(dma_data), 64'(base));
         if (dma_data !== base + DW'(i)) check("stream.order", 64'(dma_data), 64'(base + DW'(i)));
      end
      check("stream.fill", 64'(fill_level), 64'(8));
      check("stream.cnt",  64'(dunf_count), 64'(0));

      // Drain and hold in underflow long enough to saturate the counter.
      drive(0, 0, '0, 1, 0, 0);
      for (int i = 0; i < 70010; i++) cycle((i % 4096) == 0);
      check("sat.cnt",  64'(dunf_count), 64'(16'hFFFF));
      check("sat.dunf", 64'(dac_dunf),   64'(1));
      drive(0, 0, '0, 1, 0, 1);
      cycle(1);
      check("clr_vs_unf.cnt",  64'(dunf_count), 64'(1));
      check("clr_vs_unf.dunf", 64'(dac_dunf),   64'(1));

      // Random traffic with occasional sync, clear and reset.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 500) == 0, ($urandom % 4) != 0, {$urandom, $urandom},
               ($urandom % 16) != 0, ($urandom % 64) == 0, ($urandom % 32) == 0);
         cycle(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_dac_jesd204_dma_fifo.md
Name: axi_dac_jesd204_dma_fifo

Overview:
- Rate-matching buffer directly upstream of each DAC JESD204 channel; drives the channel's dma_data input.
- Accepts DMA samples on a valid/ready stream and delivers one full beat (DATA_PATH_WIDTH x 16-bit samples) per dac_clk while the channel selects DMA data.
- Primes to a programmable fill level before streaming, inserts zeros on underflow, and reports underflow events.

Parameters:
- DATA_PATH_WIDTH, 4, samples per beat; beat width DW = DATA_PATH_WIDTH*16.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 beats.
- START_LEVEL, 8, fill level (beats) required before streaming starts; legal range 1..2**DEPTH_LOG2.

Ports:
- dac_clk  in  1  sole clock.
- dac_rst  in  1  synchronous, active-high reset.
- s_valid  in  1  DMA beat valid.
- s_ready  out  1  FIFO can accept a beat.
- s_data  in  DW  DMA beat.
- dac_enable  in  1  channel selects DMA data; consume request.
- dac_data_sync  in  1  flush / resynchronise pulse.
- dma_data  out  DW  beat to channel.
- dac_dunf  out  1  sticky underflow flag.
- dunf_clr  in  1  clears dac_dunf and dunf_count.
- dunf_count  out  16  saturating underflow beat counter.
- fill_level  out  DEPTH_LOG2+1  current occupancy in beats.

Behaviour:
- Reset (dac_rst=1 at a clock edge): pointers=0, fill_level=0, state IDLE, dma_data=0, dac_dunf=0, dunf_count=0, s_ready=0 during the reset cycle and 1 on the first cycle after reset.
- Write: push when s_valid && s_ready. s_ready = (fill_level < 2**DEPTH_LOG2), no dependence on same-cycle pop. Full FIFO gives s_ready=0 even while popping.
- fill_level updates the cycle after push/pop. Simultaneous push and pop leaves fill_level unchanged. Pointers wrap modulo depth.
- State machine:
  - IDLE: dma_data <= 0, no pops. Go to FILL when dac_enable=1.
  - FILL: dma_data <= 0, no pops, no underflow counted. Go to RUN when fill_level >= START_LEVEL. Go to IDLE when dac_enable=0.
  - RUN: if dac_enable=0, go to IDLE with no pop. Otherwise, if fill_level > 0, pop and register the beat into dma_data. If fill_level = 0, this is an underflow cycle: dma_data <= 0, dac_dunf <= 1, dunf_count increments and saturates at 16'hFFFF, and the state stays RUN with no re-prime.
- Latency: the beat popped at edge N appears on dma_data after edge N; data is registered. A beat written into an empty FIFO is poppable no earlier than the next cycle. There is no write-to-read bypass, so a write into an empty FIFO in RUN still counts as an underflow on that cycle.
- dac_data_sync=1:
  - Flushes the FIFO: pointers=0, fill_level=0, state IDLE, dma_data <= 0.
  - A push in the same cycle is discarded.
  - Underflow status is unchanged.
  - Sync has priority over dac_enable.
- dunf_clr: clears dac_dunf and dunf_count. If an underflow occurs in the same cycle, the result is dac_dunf=1 and dunf_count=1 (the event wins).
- Reset has priority over everything. A reset mid-stream discards FIFO contents; any s_valid beat presented during reset is dropped.
- Samples pass through unchanged, with no reordering of the 16-bit lanes within a beat.

Test Plan:
- Reset, START_LEVEL=8: push beats 0x1..0x8 with dac_enable=1 -> dma_data=0 until fill_level=8; then dma_data=0x1,0x2,... on consecutive cycles; dac_dunf=0.
- Fill to 16 beats, hold dac_enable=0 -> s_ready=0 and fill_level=16. Write attempts with s_valid=1 are not accepted, and contents are unchanged when later read out.
- In RUN, stop writes after 8 beats -> 8 data beats, then dma_data=0 for 5 cycles. dunf_count=5, dac_dunf=1. Assert dunf_clr -> both 0 next cycle.
- Force 70000 underflow cycles -> dunf_count saturates at 0xFFFF and does not wrap.
- Mid-stream dac_data_sync pulse with 6 beats queued and s_valid=1 -> fill_level=0, state IDLE, dma_data=0. After dac_enable stays high and 8 new beats arrive, the first output is the first new beat.
- Continuous push+pop at full rate with fill_level=8 -> fill_level stays 8. A 1000-beat incrementing pattern is output in order with no gaps and no underflow.
